// File: rtl/motor_cmd_pkg.sv
// rtl/motor_cmd_pkg.sv - shared command codes, source and scheduler state types
package motor_cmd_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_FWD       = 4'b0000;
  localparam cmd_t CMD_LEFT_FWD  = 4'b0001;
  localparam cmd_t CMD_RIGHT_FWD = 4'b0010;
  localparam cmd_t CMD_REV       = 4'b0011;
  localparam cmd_t CMD_SPIN_CCW  = 4'b0100;
  localparam cmd_t CMD_SPIN_CW   = 4'b0101;
  localparam cmd_t CMD_LEFT_REV  = 4'b0110;
  localparam cmd_t CMD_RIGHT_REV = 4'b0111;
  localparam cmd_t CMD_STOP      = 4'b1000;

  typedef enum logic [1:0] {
    SRC_MANUAL  = 2'd0,
    SRC_AUTO    = 2'd1,
    SRC_ESTOP   = 2'd2,
    SRC_TIMEOUT = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/src_timeout_counter.sv
// rtl/src_timeout_counter.sv - saturating up-counter with clear and reached flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes effect at the next edge)
//   reached    : high while the count is at or beyond LIMIT-1
module src_timeout_counter #(
  parameter int unsigned LIMIT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic reached
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] CNT_MAX   = W'(LIMIT);
  localparam logic [W-1:0] CNT_REACH = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag stays up after saturation until a clear, so it acts as a sticky "due".
  assign reached = (cnt_q >= CNT_REACH);

endmodule

// File: rtl/motor_cmd_scheduler.sv
// rtl/motor_cmd_scheduler.sv - prioritised motor command arbiter and frame pacer
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   estop                   : emergency stop level, highest priority
//   auto_en/auto_cmd/auto_speed/auto_strobe : autonomous source
//   man_cmd/man_speed       : manual source levels
//   move_cmd/speed_level/valid/ready : frame handshake to the UART transmitter
//   active_src              : source of the last accepted frame
//   busy                    : high while sending or waiting out the gap
module motor_cmd_scheduler
  import motor_cmd_pkg::*;
#(
  parameter int unsigned MIN_GAP_CYCLES      = 50_000,
  parameter int unsigned HEARTBEAT_CYCLES    = 5_000_000,
  parameter int unsigned AUTO_TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       estop,
  input  logic       auto_en,
  input  logic [3:0] auto_cmd,
  input  logic [3:0] auto_speed,
  input  logic       auto_strobe,
  input  logic [3:0] man_cmd,
  input  logic [3:0] man_speed,
  output logic [3:0] move_cmd,
  output logic [3:0] speed_level,
  output logic       valid,
  input  logic       ready,
  output logic [1:0] active_src,
  output logic       busy
);

  localparam int unsigned GW = $clog2(MIN_GAP_CYCLES + 1);
  // GAP lasts GAP_LOAD+1 cycles, counting down to zero.
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP_CYCLES - 1);

  sched_state_t  state_q, state_d;
  cmd_t          move_cmd_q, move_cmd_d;
  logic [3:0]    speed_q, speed_d;
  src_t          src_q, src_d;
  src_t          active_src_q, active_src_d;
  logic [7:0]    last_sent_q, last_sent_d;
  logic          last_sent_vld_q, last_sent_vld_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  cmd_t       sel_cmd;
  logic [3:0] sel_speed;
  src_t       sel_src;
  logic       stale;
  logic       hb_due;
  logic       accept;
  logic       trigger;

  assign valid  = (state_q == ST_SEND);
  assign busy   = (state_q != ST_IDLE);
  assign accept = valid && ready;

  src_timeout_counter #(.LIMIT(AUTO_TIMEOUT_CYCLES)) u_auto_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (auto_strobe || !auto_en),
    .reached (stale)
  );

  src_timeout_counter #(.LIMIT(HEARTBEAT_CYCLES)) u_heartbeat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .reached (hb_due)
  );

  always_comb begin
    sel_cmd   = man_cmd;
    sel_speed = man_speed;
    sel_src   = SRC_MANUAL;
    if (estop) begin
      sel_cmd   = CMD_STOP;
      sel_speed = 4'd0;
      sel_src   = SRC_ESTOP;
    end else if (auto_en && stale) begin
      sel_cmd   = CMD_STOP;
      sel_speed = 4'd0;
      sel_src   = SRC_TIMEOUT;
    end else if (auto_en) begin
      sel_cmd   = auto_cmd;
      sel_speed = auto_speed;
      sel_src   = SRC_AUTO;
    end
    if (sel_cmd == CMD_STOP) begin
      sel_speed = 4'd0;
    end
  end

  // hb_due merges into the same trigger, so a change and a heartbeat landing
  // together still yield one frame.
  assign trigger = !last_sent_vld_q || ({sel_cmd, sel_speed} != last_sent_q) || hb_due;

  always_comb begin
    state_d         = state_q;
    move_cmd_d      = move_cmd_q;
    speed_d         = speed_q;
    src_d           = src_q;
    active_src_d    = active_src_q;
    last_sent_d     = last_sent_q;
    last_sent_vld_d = last_sent_vld_q;
    gap_cnt_d       = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          move_cmd_d = sel_cmd;
          speed_d    = sel_speed;
          src_d      = sel_src;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ready) begin
          last_sent_d     = {move_cmd_q, speed_q};
          last_sent_vld_d = 1'b1;
          active_src_d    = src_q;
          gap_cnt_d       = GAP_LOAD;
          state_d         = ST_GAP;
        end
      end
      ST_GAP: begin
        // A pending emergency stop cuts the gap short so STOP is not delayed.
        if (estop && (last_sent_q[7:4] != CMD_STOP)) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      move_cmd_q      <= CMD_STOP;
      speed_q         <= 4'd0;
      src_q           <= SRC_MANUAL;
      active_src_q    <= SRC_MANUAL;
      last_sent_q     <= 8'd0;
      last_sent_vld_q <= 1'b0;
      gap_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      move_cmd_q      <= move_cmd_d;
      speed_q         <= speed_d;
      src_q           <= src_d;
      active_src_q    <= active_src_d;
      last_sent_q     <= last_sent_d;
      last_sent_vld_q <= last_sent_vld_d;
      gap_cnt_q       <= gap_cnt_d;
    end
  end

  assign move_cmd    = move_cmd_q;
  assign speed_level = speed_q;
  assign active_src  = active_src_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb/tb_motor_cmd_scheduler.sv - directed self-checking bench for motor_cmd_scheduler
module tb_motor_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       estop;
  logic       auto_en;
  logic [3:0] auto_cmd;
  logic [3:0] auto_speed;
  logic       auto_strobe;
  logic [3:0] man_cmd;
  logic [3:0] man_speed;
  logic [3:0] move_cmd;
  logic [3:0] speed_level;
  logic       valid;
  logic       ready;
  logic [1:0] active_src;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_n  = 0;
  int acc_cyc = 0;
  logic [3:0] acc_cmd = 4'd0;
  logic [3:0] acc_spd = 4'd0;

  motor_cmd_scheduler #(
    .MIN_GAP_CYCLES      (8),
    .HEARTBEAT_CYCLES    (64),
    .AUTO_TIMEOUT_CYCLES (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .estop       (estop),
    .auto_en     (auto_en),
    .auto_cmd    (auto_cmd),
    .auto_speed  (auto_speed),
    .auto_strobe (auto_strobe),
    .man_cmd     (man_cmd),
    .man_speed   (man_speed),
    .move_cmd    (move_cmd),
    .speed_level (speed_level),
    .valid       (valid),
    .ready       (ready),
    .active_src  (active_src),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Transfers are logged mid-cycle; the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (valid && ready) begin
      acc_n   = acc_n + 1;
      acc_cyc = cyc;
      acc_cmd = move_cmd;
      acc_spd = speed_level;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string tag, input int prev, input int bound);
    int k = 0;
    while (acc_n == prev && k < bound) begin
      tick();
      k++;
    end
    chk(tag, 32'(acc_n > prev), 32'd1);
  endtask

  int r, a, n, k, e, s;

  initial begin
    rst_n = 1'b0; estop = 1'b0; ready = 1'b1;
    auto_en = 1'b0; auto_cmd = 4'd0; auto_speed = 4'd0; auto_strobe = 1'b0;
    man_cmd = 4'b0000; man_speed = 4'd5;
    repeat (3) tick();
    chk("rst_cmd", 32'(move_cmd), 32'd8);
    chk("rst_spd", 32'(speed_level), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_src", 32'(active_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // First frame after reset, then the heartbeat resend.
    rst_n = 1'b1; r = cyc; n = acc_n;
    wait_acc("first_acc", n, 5);
    chk("first_lat", 32'(acc_cyc - r), 32'd1);
    chk("first_val", {acc_cmd, acc_spd}, {4'b0000, 4'd5});
    chk("first_src", 32'(active_src), 32'd0);
    chk("first_busy", 32'(busy), 32'd1);
    a = acc_cyc; n = acc_n;
    wait_acc("hb_acc", n, 100);
    chk("hb_interval", 32'(acc_cyc - a), 32'd65);
    chk("hb_val", {acc_cmd, acc_spd}, {4'b0000, 4'd5});

    // Change during GAP goes out only after the full gap.
    a = acc_cyc; n = acc_n;
    man_cmd = 4'b0101; man_speed = 4'd3;
    wait_acc("gap_acc", n, 30);
    chk("gap_interval", 32'(acc_cyc - a), 32'd10);
    chk("gap_val", {acc_cmd, acc_spd}, {4'b0101, 4'd3});

    // Stall in SEND with the selection moving underneath.
    n = acc_n;
    ready = 1'b0; man_cmd = 4'b0011; man_speed = 4'd2;
    k = 0;
    while (!valid && k < 20) begin tick(); k++; end
    chk("stall_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      man_cmd = 4'(i % 8); man_speed = 4'(i);
      tick();
      chk("stall_hold", {valid, move_cmd, speed_level}, {1'b1, 4'b0011, 4'd2});
    end
    man_cmd = 4'b0110; man_speed = 4'd6; ready = 1'b1;
    wait_acc("stall_acc", n, 3);
    chk("stall_val", {acc_cmd, acc_spd}, {4'b0011, 4'd2});
    n = acc_n;
    wait_acc("stall_next_acc", n, 30);
    chk("stall_next_val", {acc_cmd, acc_spd}, {4'b0110, 4'd6});

    // Emergency stop during GAP.
    man_cmd = 4'b0000; man_speed = 4'd5; n = acc_n;
    wait_acc("fwd_acc", n, 30);
    chk("fwd_val", {acc_cmd, acc_spd}, {4'b0000, 4'd5});
    repeat (2) tick();
    estop = 1'b1; e = cyc; n = acc_n;
    wait_acc("estop_acc", n, 5);
    chk("estop_lat", 32'(acc_cyc - e), 32'd2);
    chk("estop_val", {acc_cmd, acc_spd}, {4'b1000, 4'd0});
    tick();
    chk("estop_src", 32'(active_src), 32'd2);
    a = acc_cyc; n = acc_n;
    wait_acc("estop_hb_acc", n, 100);
    chk("estop_hb_interval", 32'(acc_cyc - a), 32'd65);
    chk("estop_hb_val", {acc_cmd, acc_spd}, {4'b1000, 4'd0});
    estop = 1'b0; n = acc_n;
    wait_acc("release_acc", n, 30);
    chk("release_val", {acc_cmd, acc_spd}, {4'b0000, 4'd5});
    repeat (12) tick();

    // Auto source goes stale, then recovers on a fresh strobe.
    n = acc_n;
    auto_en = 1'b1; auto_cmd = 4'b0100; auto_speed = 4'd2; auto_strobe = 1'b1; s = cyc;
    tick();
    auto_strobe = 1'b0;
    wait_acc("auto_acc", n, 5);
    chk("auto_lat", 32'(acc_cyc - s), 32'd1);
    chk("auto_val", {acc_cmd, acc_spd}, {4'b0100, 4'd2});
    tick();
    chk("auto_src", 32'(active_src), 32'd1);
    n = acc_n;
    wait_acc("stale_acc", n, 60);
    chk("stale_lat", 32'(acc_cyc - s), 32'd33);
    chk("stale_val", {acc_cmd, acc_spd}, {4'b1000, 4'd0});
    a = acc_cyc; n = acc_n;
    auto_cmd = 4'b0011; auto_speed = 4'd7; auto_strobe = 1'b1;
    tick();
    auto_strobe = 1'b0;
    chk("stale_src", 32'(active_src), 32'd3);
    wait_acc("recover_acc", n, 30);
    chk("recover_interval", 32'(acc_cyc - a), 32'd10);
    chk("recover_val", {acc_cmd, acc_spd}, {4'b0011, 4'd7});
    tick();
    chk("recover_src", 32'(active_src), 32'd1);

    // Reset while a frame is pending.
    auto_en = 1'b0; man_cmd = 4'b0101; man_speed = 4'd4; ready = 1'b0;
    k = 0;
    while (!valid && k < 20) begin tick(); k++; end
    chk("pre_rst_valid", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_cmd", 32'(move_cmd), 32'd8);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1; ready = 1'b1; r = cyc; n = acc_n;
    wait_acc("post_rst_acc", n, 5);
    chk("post_rst_lat", 32'(acc_cyc - r), 32'd1);
    chk("post_rst_val", {acc_cmd, acc_spd}, {4'b0101, 4'd4});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
